// File: rtl/io_pad_pkg.sv
// ============================================================================
// Module : io_pad_pkg
// Brief  : Shared types and limits for the HJ110 SIO bidirectional pad model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package io_pad_pkg;

  typedef enum logic {
    PAD_PUSH_PULL  = 1'b0,
    PAD_OPEN_DRAIN = 1'b1
  } pad_mode_e;

  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_FILTER_LEN  = 15;
  localparam int FILTER_CNT_W    = $clog2(MAX_FILTER_LEN + 1);

endpackage

`default_nettype wire

// File: rtl/io_pad_in_filter.sv
// ============================================================================
// Module : io_pad_in_filter
// Brief  : Pad-to-core synchronizer chain followed by an optional glitch filter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module io_pad_in_filter
  import io_pad_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 0,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int SYNC_N = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;
  localparam int FILT_N = (FILTER_LEN > MAX_FILTER_LEN) ? MAX_FILTER_LEN : FILTER_LEN;

  logic w_sync;

  generate
    if (SYNC_N == 0) begin : g_sync_bypass
      assign w_sync = i_d;
    end else begin : g_sync_chain
      logic [SYNC_N-1:0] r_sync;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= {SYNC_N{RESET_VAL}};
        end else begin
          r_sync[0] <= i_d;
          for (int i = 1; i < SYNC_N; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_sync = r_sync[SYNC_N-1];
    end
  endgenerate

  generate
    if (FILT_N == 0) begin : g_filter_bypass
      assign o_q = w_sync;
    end else begin : g_filter
      logic [FILTER_CNT_W-1:0] r_cnt;
      logic                    r_q;

      // New value is accepted on the FILT_N-th consecutive differing sample.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_q   <= RESET_VAL;
        end else if (w_sync == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == FILTER_CNT_W'(FILT_N - 1)) begin
          r_cnt <= '0;
          r_q   <= w_sync;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_q = r_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/io_pad_bidir.sv
// ============================================================================
// Module : io_pad_bidir
// Brief  : Bidirectional IO pad: push-pull/open-drain driver, weak pull-ups,
//          power-good gating and a filtered input path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module io_pad_bidir
  import io_pad_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 0,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dout,
  input  logic eno,
  input  logic od,
  input  logic eni,
  input  logic pu1,
  input  logic pu2,
  input  logic vcc,
  input  logic vdd,
  input  logic gnd,
  output logic din,
  inout  wire  spad
);

  pad_mode_e w_mode;
  logic      w_pwr_ok;
  logic      w_drv_on;
  logic      w_pull_on;
  logic      w_pad_in;
  logic      w_in_gated;

  assign w_mode   = pad_mode_e'(od);
  assign w_pwr_ok = vcc & vdd & ~gnd;

  // Open-drain only ever drives a strong 0; a 1 is left to the pull-ups.
  assign w_drv_on  = eno & w_pwr_ok & ((w_mode == PAD_PUSH_PULL) | ~dout);
  assign w_pull_on = w_pwr_ok & (pu1 | pu2);

  assign spad = w_drv_on ? dout : 1'bz;
  assign (weak0, weak1) spad = w_pull_on ? 1'b1 : 1'bz;

  assign w_pad_in   = (spad === 1'b1);
  assign w_in_gated = w_pad_in & eni & w_pwr_ok;

  io_pad_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .RESET_VAL   (RESET_VAL)
  ) u_in_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_in_gated),
    .o_q   (din)
  );

endmodule

`default_nettype wire

// File: tb/tb_io_pad_bidir.sv
// ============================================================================
// Module : tb_io_pad_bidir
// Brief  : Directed self-checking bench; pad A has no filter, pad B FILTER_LEN=3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_io_pad_bidir;

  logic clk = 1'b0;
  logic rst_n, dout, eno, od, eni, pu1, pu2, vcc, vdd, gnd;
  logic din_a, din_b;
  logic r_ext_en, r_ext_val;
  wire  spad_a, spad_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign spad_a = r_ext_en ? r_ext_val : 1'bz;
  assign spad_b = r_ext_en ? r_ext_val : 1'bz;

  io_pad_bidir #(.SYNC_STAGES(2), .FILTER_LEN(0), .RESET_VAL(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dout(dout), .eno(eno), .od(od), .eni(eni),
    .pu1(pu1), .pu2(pu2), .vcc(vcc), .vdd(vdd), .gnd(gnd),
    .din(din_a), .spad(spad_a)
  );

  io_pad_bidir #(.SYNC_STAGES(2), .FILTER_LEN(3), .RESET_VAL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dout(dout), .eno(eno), .od(od), .eni(eni),
    .pu1(pu1), .pu2(pu2), .vcc(vcc), .vdd(vdd), .gnd(gnd),
    .din(din_b), .spad(spad_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // After a pad step applied just past a falling edge, din_a follows at the
  // 2nd rising edge and din_b at the 5th.
  task automatic check_step(input string tag, input logic v);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check({tag, "_a"}, din_a, (k >= 2) ? v : ~v);
      check({tag, "_b"}, din_b, (k >= 5) ? v : ~v);
    end
  endtask

  initial begin
    rst_n = 1'b0; dout = 1'b1; eno = 1'b1; od = 1'b0; eni = 1'b0;
    pu1 = 1'b0; pu2 = 1'b0; vcc = 1'b1; vdd = 1'b1; gnd = 1'b0;
    r_ext_en = 1'b0; r_ext_val = 1'b0;

    // Reset state; driver is live even while in reset
    wait_cycles(2);
    #1;
    check("rst_din_a", din_a, 1'b0);
    check("rst_din_b", din_b, 1'b0);
    check("rst_spad_drive", spad_a, 1'b1);
    rst_n = 1'b1;

    // Push-pull drive, input disabled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dout = i[0];
      #1;
      check("pp_spad", spad_a, dout);
      check("pp_din", din_a, 1'b0);
    end

    // Open-drain with pull-ups
    od = 1'b1; pu1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dout = i[0];
      #1;
      check("od_pu1_spad", spad_a, dout);
    end
    pu1 = 1'b0; pu2 = 1'b1; dout = 1'b1;
    #1;
    check("od_pu2_spad", spad_a, 1'b1);
    pu2 = 1'b0;
    r_ext_en = 1'b1; r_ext_val = 1'b0;
    #1;
    check("od_released", spad_a, 1'b0);

    // Input latency: external drive, output disabled
    eno = 1'b0; eni = 1'b1; od = 1'b0;
    wait_cycles(6);
    check("in_idle_a", din_a, 1'b0);
    check("in_idle_b", din_b, 1'b0);
    r_ext_val = 1'b1;
    check_step("rise", 1'b1);
    r_ext_val = 1'b0;
    check_step("fall", 1'b0);

    // Glitch filter: 2-cycle pulse is swallowed
    @(negedge clk);
    r_ext_val = 1'b1;
    wait_cycles(2);
    r_ext_val = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("glitch2_b", din_b, 1'b0);
    end

    // 5-cycle pulse passes with 5-cycle latency on both edges
    r_ext_val = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("pulse5_rise_b", din_b, k >= 5);
    end
    r_ext_val = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("pulse5_fall_b", din_b, k < 5);
    end

    // Asynchronous reset between edges, driver unaffected
    eno = 1'b1; dout = 1'b1; r_ext_val = 1'b1;
    wait_cycles(7);
    check("pre_rst_a", din_a, 1'b1);
    check("pre_rst_b", din_b, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", din_a, 1'b0);
    check("async_rst_b", din_b, 1'b0);
    check("rst_spad", spad_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    check_step("rst_rel", 1'b1);
    check("post_rst_spad", spad_a, 1'b1);

    // Power gating: driver released, input path forced low
    dout = 1'b0; vcc = 1'b0;
    wait_cycles(7);
    check("pwr_off_din_a", din_a, 1'b0);
    check("pwr_off_din_b", din_b, 1'b0);
    check("pwr_off_spad_ext1", spad_a, 1'b1);
    dout = 1'b1; r_ext_val = 1'b0;
    #1;
    check("pwr_off_spad_ext0", spad_a, 1'b0);
    r_ext_en = 1'b0; dout = 1'b0; vcc = 1'b1;
    #1;
    check("pwr_on_spad0", spad_a, 1'b0);
    dout = 1'b1;
    #1;
    check("pwr_on_spad1", spad_a, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
